// File: rtl/bootprom_pkg.sv
// rtl/bootprom_pkg.sv - shared types and constants for the boot EPROM controller
package bootprom_pkg;

  localparam int ROM_AW = 15;
  localparam int ROM_DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    ACK,
    RECOVER
  } state_t;

  // One-hot grant: bit 0 is the CPU port, bit 1 the debug/loader port.
  localparam logic [1:0] GNT_CPU = 2'b01;
  localparam logic [1:0] GNT_DBG = 2'b10;

endpackage

// File: rtl/bootprom_if.sv
// rtl/bootprom_if.sv - requester handshakes and EPROM pins of the boot store
interface bootprom_if;
  import bootprom_pkg::*;

  logic              cpu_req;
  logic [ROM_AW-1:0] cpu_addr;
  logic              cpu_ack;
  logic              dbg_req;
  logic [ROM_AW-1:0] dbg_addr;
  logic              dbg_ack;
  logic [ROM_DW-1:0] rd_data;
  logic [ROM_AW-1:0] rom_addr;
  logic              rom_ce_n;
  logic              rom_oe_n;
  logic [7:0]        rom_data_h;
  logic [7:0]        rom_data_l;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data_h, rom_data_l,
    output cpu_ack, dbg_ack, rd_data, rom_addr, rom_ce_n, rom_oe_n, busy
  );

  modport master (
    output cpu_req, cpu_addr, dbg_req, dbg_addr, rom_data_h, rom_data_l,
    input  cpu_ack, dbg_ack, rd_data, rom_addr, rom_ce_n, rom_oe_n, busy
  );

endinterface

// File: rtl/bootprom_arb.sv
// rtl/bootprom_arb.sv - two-way round-robin arbiter between CPU and debug port
module bootprom_arb
  import bootprom_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr=0 favours the CPU on a tie, ptr=1 favours the debug port.
  logic ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? GNT_DBG : GNT_CPU;
    end
  end

  // Only a contested grant hands priority to the loser.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (advance && (req == 2'b11)) begin
      ptr <= ~ptr;
    end
  end

endmodule

// File: rtl/bootprom_ctl.sv
// rtl/bootprom_ctl.sv - paired 27256 boot EPROM sequencer with shared req/ack ports
module bootprom_ctl
  import bootprom_pkg::*;
#(
  parameter int ACCESS_CYCLES   = 3,
  parameter int RECOVERY_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  bootprom_if.slave  bus
);

  localparam logic [3:0] ACC_LOAD = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] REC_LOAD = 4'(RECOVERY_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] gnt;
  logic [1:0] gnt_q;
  logic       own_req;

  bootprom_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({bus.dbg_req, bus.cpu_req}),
    .advance (state == IDLE),
    .gnt     (gnt)
  );

  assign own_req = (gnt_q[0] & bus.cpu_req) | (gnt_q[1] & bus.dbg_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      gnt_q        <= '0;
      bus.rom_ce_n <= 1'b1;
      bus.rom_oe_n <= 1'b1;
      bus.rom_addr <= '0;
      bus.rd_data  <= '0;
      bus.cpu_ack  <= 1'b0;
      bus.dbg_ack  <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req || bus.dbg_req) begin
            state        <= SETUP;
            gnt_q        <= gnt;
            bus.rom_addr <= gnt[1] ? bus.dbg_addr : bus.cpu_addr;
            bus.rom_ce_n <= 1'b0;
            bus.busy     <= 1'b1;
          end
        end
        SETUP: begin
          state        <= ACCESS;
          cnt          <= ACC_LOAD;
          bus.rom_oe_n <= 1'b0;
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            // The word is captured even when the requester has gone away.
            bus.rd_data  <= {bus.rom_data_h, bus.rom_data_l};
            bus.rom_oe_n <= 1'b1;
            if (own_req) begin
              state <= ACK;
            end else begin
              state        <= RECOVER;
              cnt          <= REC_LOAD;
              bus.rom_ce_n <= 1'b1;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ACK: begin
          if (own_req) begin
            bus.cpu_ack <= gnt_q[0];
            bus.dbg_ack <= gnt_q[1];
          end else begin
            state        <= RECOVER;
            cnt          <= REC_LOAD;
            bus.cpu_ack  <= 1'b0;
            bus.dbg_ack  <= 1'b0;
            bus.rom_ce_n <= 1'b1;
          end
        end
        RECOVER: begin
          if (cnt == 4'd0) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bootprom_ctl.sv
// tb/tb_bootprom_ctl.sv - randomized, model-checked bench for bootprom_ctl
module tb_bootprom_ctl;

  localparam int ACC0 = 3;
  localparam int REC0 = 1;
  localparam int ACC1 = 1;
  localparam int REC1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [2];
  logic        req_d [2][2];
  logic [14:0] addr_d [2][2];
  logic [7:0]  mem_h [0:32767];
  logic [7:0]  mem_l [0:32767];

  bootprom_if if0 ();
  bootprom_if if1 ();

  bootprom_ctl #(.ACCESS_CYCLES(ACC0), .RECOVERY_CYCLES(REC0)) dut0 (
    .clk (clk), .reset (rst[0]), .bus (if0)
  );
  bootprom_ctl #(.ACCESS_CYCLES(ACC1), .RECOVERY_CYCLES(REC1)) dut1 (
    .clk (clk), .reset (rst[1]), .bus (if1)
  );

  assign if0.cpu_req    = req_d[0][0];
  assign if0.cpu_addr   = addr_d[0][0];
  assign if0.dbg_req    = req_d[0][1];
  assign if0.dbg_addr   = addr_d[0][1];
  assign if0.rom_data_h = mem_h[if0.rom_addr];
  assign if0.rom_data_l = mem_l[if0.rom_addr];
  assign if1.cpu_req    = req_d[1][0];
  assign if1.cpu_addr   = addr_d[1][0];
  assign if1.dbg_req    = req_d[1][1];
  assign if1.dbg_addr   = addr_d[1][1];
  assign if1.rom_data_h = mem_h[if1.rom_addr];
  assign if1.rom_data_l = mem_l[if1.rom_addr];

  logic        o_ce_n [2], o_oe_n [2], o_busy [2], o_cack [2], o_dack [2];
  logic [14:0] o_addr [2];
  logic [15:0] o_data [2];
  assign o_ce_n[0] = if0.rom_ce_n;  assign o_ce_n[1] = if1.rom_ce_n;
  assign o_oe_n[0] = if0.rom_oe_n;  assign o_oe_n[1] = if1.rom_oe_n;
  assign o_busy[0] = if0.busy;      assign o_busy[1] = if1.busy;
  assign o_cack[0] = if0.cpu_ack;   assign o_cack[1] = if1.cpu_ack;
  assign o_dack[0] = if0.dbg_ack;   assign o_dack[1] = if1.dbg_ack;
  assign o_addr[0] = if0.rom_addr;  assign o_addr[1] = if1.rom_addr;
  assign o_data[0] = if0.rd_data;   assign o_data[1] = if1.rd_data;

  int vectors = 0;
  int errs    = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      if (errs < 40) $display("FAIL %s inst%0d t=%0t actual=%h required=%h", nm, i, $time, act, exp);
    end
  endtask

  function automatic logic ack_of(input int i, input int p);
    return p ? o_dack[i] : o_cack[i];
  endfunction

  // Reference model: each read is a timeline measured from its grant edge.
  int          m_g [2], m_rs [2];
  bit          m_active [2], m_rec [2], m_who [2], m_ptr [2];
  logic        e_ce_n [2], e_oe_n [2], e_busy [2], e_cack [2], e_dack [2];
  logic [14:0] e_addr [2];
  logic [15:0] e_data [2];

  function automatic int acc_of(input int i); return i ? ACC1 : ACC0; endfunction
  function automatic int rec_of(input int i); return i ? REC1 : REC0; endfunction

  task automatic start_rec(input int i);
    m_active[i] = 0; m_rec[i] = 1; m_rs[i] = cyc;
    e_ce_n[i] = 1; e_oe_n[i] = 1; e_cack[i] = 0; e_dack[i] = 0;
  endtask

  task automatic model_step(input int i);
    bit cr, dr, own;
    int k;
    cr = req_d[i][0];
    dr = req_d[i][1];
    if (rst[i]) begin
      m_active[i] = 0; m_rec[i] = 0; m_ptr[i] = 0;
      e_ce_n[i] = 1; e_oe_n[i] = 1; e_busy[i] = 0; e_cack[i] = 0; e_dack[i] = 0;
      e_addr[i] = '0; e_data[i] = '0;
    end else if (m_rec[i]) begin
      if (cyc == m_rs[i] + rec_of(i)) begin
        m_rec[i] = 0; e_busy[i] = 0;
      end
    end else if (m_active[i]) begin
      k   = cyc - m_g[i];
      own = m_who[i] ? dr : cr;
      if (k <= acc_of(i)) begin
        e_oe_n[i] = 0;
      end else if (k == acc_of(i) + 1) begin
        e_oe_n[i] = 1;
        e_data[i] = {mem_h[e_addr[i]], mem_l[e_addr[i]]};
        if (!own) start_rec(i);
      end else if (own) begin
        e_cack[i] = !m_who[i];
        e_dack[i] = m_who[i];
      end else begin
        start_rec(i);
      end
    end else if (cr || dr) begin
      if (cr && dr) begin
        m_who[i] = m_ptr[i];
        m_ptr[i] = !m_who[i];
      end else begin
        m_who[i] = dr;
      end
      m_active[i] = 1; m_g[i] = cyc;
      e_addr[i] = m_who[i] ? addr_d[i][1] : addr_d[i][0];
      e_ce_n[i] = 0; e_busy[i] = 1;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
    model_step(0);
    model_step(1);
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("rom_ce_n", i, 32'(o_ce_n[i]), 32'(e_ce_n[i]));
        chk("rom_oe_n", i, 32'(o_oe_n[i]), 32'(e_oe_n[i]));
        chk("busy",     i, 32'(o_busy[i]), 32'(e_busy[i]));
        chk("cpu_ack",  i, 32'(o_cack[i]), 32'(e_cack[i]));
        chk("dbg_ack",  i, 32'(o_dack[i]), 32'(e_dack[i]));
        chk("rom_addr", i, 32'(o_addr[i]), 32'(e_addr[i]));
        chk("rd_data",  i, 32'(o_data[i]), 32'(e_data[i]));
      end
    end
  end

  task automatic wait_ack(input int i, input int p, input logic val);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (ack_of(i, p) == val) return;
    end
    chk("wait_ack_timeout", i, 32'(ack_of(i, p)), 32'(val));
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (!o_busy[i]) return;
    end
    chk("wait_idle_timeout", i, 32'(o_busy[i]), 32'd0);
  endtask

  // Raise a request at a negedge, count edges until its ack and OE_n-low cycles.
  task automatic do_read(input int i, input int p, input logic [14:0] a, output int lat, output int oe);
    req_d[i][p] = 1'b1;
    addr_d[i][p] = a;
    lat = 0;
    oe  = 0;
    @(posedge clk);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (!o_oe_n[i]) oe++;
      if (ack_of(i, p)) return;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic requester(input int i, input int p, input int n);
    int hold;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      req_d[i][p]  = 1'b1;
      addr_d[i][p] = 15'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        hold = $urandom_range(1, 8);
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          if (ack_of(i, p)) break;
        end
      end else begin
        for (int c = 0; c < 400; c++) begin
          @(negedge clk);
          if (ack_of(i, p)) break;
          if ($urandom_range(0, 3) == 0) addr_d[i][p] = 15'($urandom);
          if (c == 399) chk("req_timeout", i, 32'(ack_of(i, p)), 32'd1);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      req_d[i][p] = 1'b0;
      if (ack_of(i, p)) wait_ack(i, p, 1'b0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog");
  end

  int lat, oe, seen, recs, gap;

  initial begin
    for (int a = 0; a < 32768; a++) begin
      mem_h[a] = 8'($urandom);
      mem_l[a] = 8'($urandom);
    end
    mem_h[0] = 8'h00;       mem_l[0] = 8'h01;
    mem_h[15'h100] = 8'hA5; mem_l[15'h100] = 8'h5A;
    mem_h[15'h200] = 8'h3C; mem_l[15'h200] = 8'hC3;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1;
      for (int p = 0; p < 2; p++) begin
        req_d[i][p]  = 1'b0;
        addr_d[i][p] = '0;
      end
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);

    // Single CPU read of word 0.
    do_read(0, 0, 15'h0000, lat, oe);
    chk("t1_ack_latency", 0, 32'(lat), 32'd5);
    chk("t1_oe_width", 0, 32'(oe), 32'd3);
    chk("t1_rd_data", 0, 32'(o_data[0]), 32'h0001);
    req_d[0][0] = 1'b0;
    @(negedge clk);
    chk("t1_ack_fall", 0, 32'(o_cack[0]), 32'd0);
    chk("t1_recover_ce", 0, 32'(o_ce_n[0]), 32'd1);
    @(negedge clk);
    chk("t1_idle_busy", 0, 32'(o_busy[0]), 32'd0);

    // Tie: CPU first, debug served afterwards without re-request.
    req_d[0][0] = 1'b1; addr_d[0][0] = 15'h0004;
    req_d[0][1] = 1'b1; addr_d[0][1] = 15'h7FFF;
    wait_ack(0, 0, 1'b1);
    chk("t2_cpu_first", 0, 32'(o_dack[0]), 32'd0);
    chk("t2_cpu_data", 0, 32'(o_data[0]), {16'd0, mem_h[4], mem_l[4]});
    req_d[0][0] = 1'b0;
    wait_ack(0, 1, 1'b1);
    chk("t2_dbg_data", 0, 32'(o_data[0]), {16'd0, mem_h[15'h7FFF], mem_l[15'h7FFF]});
    req_d[0][1] = 1'b0;
    wait_idle(0);
    @(negedge clk);
    req_d[0][0] = 1'b1; addr_d[0][0] = 15'h0020;
    req_d[0][1] = 1'b1; addr_d[0][1] = 15'h0030;
    for (int n = 0; n < 100 && !o_cack[0] && !o_dack[0]; n++) @(negedge clk);
    chk("t2_dbg_second_tie", 0, 32'(o_dack[0]), 32'd1);
    req_d[0][1] = 1'b0;
    wait_ack(0, 0, 1'b1);
    req_d[0][0] = 1'b0;
    wait_idle(0);
    @(negedge clk);

    // Debug abort during ACCESS, then a normal CPU read.
    req_d[0][1] = 1'b1; addr_d[0][1] = 15'h0055;
    repeat (3) @(negedge clk);
    req_d[0][1] = 1'b0;
    seen = 0; recs = 0;
    for (int n = 0; n < 50 && o_busy[0]; n++) begin
      @(negedge clk);
      if (o_dack[0]) seen++;
      if (o_busy[0] && o_ce_n[0]) recs++;
    end
    chk("t4_no_dbg_ack", 0, 32'(seen), 32'd0);
    chk("t4_recover_cycles", 0, 32'(recs), 32'(REC0));
    chk("t4_aborted_data", 0, 32'(o_data[0]), {16'd0, mem_h[15'h55], mem_l[15'h55]});
    @(negedge clk);
    do_read(0, 0, 15'h0066, lat, oe);
    chk("t4_cpu_latency", 0, 32'(lat), 32'd5);
    req_d[0][0] = 1'b0;
    wait_idle(0);
    @(negedge clk);

    // Address moves after grant: the latched one is used.
    req_d[0][0] = 1'b1; addr_d[0][0] = 15'h0100;
    @(negedge clk);
    addr_d[0][0] = 15'h0200;
    wait_ack(0, 0, 1'b1);
    chk("t6_rom_addr", 0, 32'(o_addr[0]), 32'h0100);
    chk("t6_rd_data", 0, 32'(o_data[0]), 32'hA55A);
    req_d[0][0] = 1'b0;
    wait_idle(0);
    @(negedge clk);

    // Tie leaves priority with debug, then reset in ACCESS must restore CPU priority.
    req_d[0][0] = 1'b1; req_d[0][1] = 1'b1;
    wait_ack(0, 0, 1'b1);
    req_d[0][0] = 1'b0;
    wait_ack(0, 1, 1'b1);
    req_d[0][1] = 1'b0;
    wait_idle(0);
    @(negedge clk);
    req_d[0][0] = 1'b1; addr_d[0][0] = 15'h0077;
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    req_d[0][0] = 1'b0;
    @(negedge clk);
    chk("t5_ce_n", 0, 32'(o_ce_n[0]), 32'd1);
    chk("t5_oe_n", 0, 32'(o_oe_n[0]), 32'd1);
    chk("t5_acks", 0, {30'd0, o_cack[0], o_dack[0]}, 32'd0);
    chk("t5_rd_data", 0, 32'(o_data[0]), 32'd0);
    chk("t5_busy", 0, 32'(o_busy[0]), 32'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    req_d[0][0] = 1'b1; req_d[0][1] = 1'b1;
    for (int n = 0; n < 100 && !o_cack[0] && !o_dack[0]; n++) @(negedge clk);
    chk("t5_cpu_first", 0, 32'(o_cack[0]), 32'd1);
    req_d[0][0] = 1'b0;
    wait_ack(0, 1, 1'b1);
    req_d[0][1] = 1'b0;
    wait_idle(0);

    // Short access / long recovery build, back-to-back CPU reads.
    @(negedge clk);
    do_read(1, 0, 15'h0010, lat, oe);
    chk("t3_ack_latency", 1, 32'(lat), 32'd3);
    chk("t3_oe_width", 1, 32'(oe), 32'd1);
    req_d[1][0] = 1'b0;
    recs = 0; gap = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!o_ce_n[1]) break;
      gap++;
      if (o_busy[1]) recs++;
      if (n == 0) begin
        req_d[1][0] = 1'b1; addr_d[1][0] = 15'h0011;
      end
    end
    chk("t3_ce_recover_width", 1, 32'(recs), 32'(REC1));
    wait_ack(1, 0, 1'b1);
    chk("t3_second_data", 1, 32'(o_data[1]), {16'd0, mem_h[15'h11], mem_l[15'h11]});
    req_d[1][0] = 1'b0;
    wait_idle(1);

    fork
      requester(0, 0, 30);
      requester(0, 1, 30);
      requester(1, 0, 30);
      requester(1, 1, 30);
    join
    wait_idle(0);
    wait_idle(1);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/bootprom_ctl.md
Name: bootprom_ctl

Overview:
- Sequences the paired 27256 boot EPROMs (high-byte and low-byte chips on a shared 15-bit address) as one 16-bit word store.
- Shares that store between two requesters: the CPU bus interface and the debug/loader port.
- Drives chip enable, output enable and address, and waits a programmable access time.
- Latches the 16-bit word and returns it with a four-phase req/ack handshake.

Parameters:
- ACCESS_CYCLES, 3, number of cycles OE_n is held low before data is sampled; legal range 1..15.
- RECOVERY_CYCLES, 1, number of cycles CE_n is held high between accesses; legal range 1..15.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- cpu_req, input, 1, CPU read request; held high until cpu_ack is seen.
- cpu_addr, input, 15, CPU word address.
- cpu_ack, output, 1, CPU read complete; rd_data is valid while high.
- dbg_req, input, 1, debug read request; same rules as cpu_req.
- dbg_addr, input, 15, debug word address.
- dbg_ack, output, 1, debug read complete; rd_data is valid while high.
- rd_data, output, 16, latched word: {high chip, low chip}.
- rom_addr, output, 15, address to both EPROMs.
- rom_ce_n, output, 1, chip enable to both EPROMs, active low.
- rom_oe_n, output, 1, output enable to both EPROMs, active low.
- rom_data_h, input, 8, data from the high-byte EPROM.
- rom_data_l, input, 8, data from the low-byte EPROM.
- busy, output, 1, high in every state except IDLE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values: state=IDLE, rom_ce_n=1, rom_oe_n=1, rom_addr=0, rd_data=0, cpu_ack=0, dbg_ack=0, busy=0, round-robin pointer=CPU.
- States:
  - IDLE -> SETUP: taken when any req is high. The grant winner's address is latched into rom_addr and its identity into a grant register.
  - SETUP: rom_ce_n=0, rom_oe_n=1, lasts 1 cycle, then ACCESS.
  - ACCESS: rom_ce_n=0, rom_oe_n=0 for ACCESS_CYCLES cycles, counted by a 4-bit down-counter. On the last ACCESS edge, rd_data <= {rom_data_h, rom_data_l}.
  - ACCESS exit, granted req still high: go to ACK.
  - ACCESS exit, granted req low: go to RECOVER with no ack. This is an aborted request; rd_data is still updated.
  - ACK: granted ack=1, rom_ce_n=0, rom_oe_n=1. Stays until the granted req is sampled low; the ack drops on that same edge and the state moves to RECOVER.
  - RECOVER: rom_ce_n=1, rom_oe_n=1 for RECOVERY_CYCLES cycles, then IDLE.
- Latency: with req sampled high in IDLE at edge E, ack rises at edge E+2+ACCESS_CYCLES. For ACCESS_CYCLES=3 this is E+5.
- Arbitration is two-way round-robin:
  - With one req high, that requester wins.
  - With both high, the pointer side wins and the pointer then moves to the loser.
  - After reset, CPU wins the first tie.
- The non-granted req is ignored until the FSM returns to IDLE; it is never dropped and needs no re-request.
- Address changes during a grant are ignored because rom_addr is latched at grant.
- rd_data holds its value between transactions.
- cpu_ack and dbg_ack are never high simultaneously.
- Reset mid-operation: every output returns to its reset value on the reset edge, any partial transaction is abandoned, and no ack is issued.
- All outputs are registered; there is no combinational path from req to rom_* or ack.

Decomposition:
- bootprom_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, ACK, RECOVER);
  - ROM_AW=15 and ROM_DW=16;
  - grant encoding constants GNT_CPU and GNT_DBG.
- One sub-module, bootprom_arb: the 2-way round-robin arbiter, with inputs req[1:0], a pointer register and an advance strobe, producing a one-hot grant.

Test Plan:
- Reset, then cpu_req=1 with cpu_addr=15'h0000, ROM model h=8'h00, l=8'h01. Required: rom_oe_n low for exactly 3 cycles, cpu_ack rises 5 edges after req is sampled, rd_data=16'h0001. Drop req: ack falls, rom_ce_n high 1 cycle, busy=0.
- cpu_req and dbg_req raised on the same edge, addresses 15'h0004 and 15'h7FFF. Required: CPU served first. dbg is served after CPU's RECOVER with no re-request, rd_data={mem_h[7FFF],mem_l[7FFF]}. A following simultaneous pair is served dbg-first.
- Build with ACCESS_CYCLES=1, RECOVERY_CYCLES=4, back-to-back CPU reads at 15'h0010 and 15'h0011. Required: OE_n low pulse width 1 cycle, CE_n high gap 4 cycles between reads, ack latency 3 edges.
- dbg_req dropped during ACCESS. Required: no dbg_ack, FSM passes through RECOVER to IDLE, and a subsequent cpu_req completes normally.
- Assert reset during ACCESS. Required: on the next edge rom_ce_n=1, rom_oe_n=1, acks=0, rd_data=0, busy=0. A post-reset simultaneous request grants CPU first.
- Change cpu_addr from 15'h0100 to 15'h0200 during SETUP/ACCESS. Required: rom_addr stays 15'h0100 and rd_data holds the word at 15'h0100.
